imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the 4 KB instruction memory that the core reads through its 10-bit word address.
- Accepts a byte stream over a valid/ready handshake: 16-bit word count, big-endian 32-bit instruction words, then a 1-byte XOR checksum.
- Issues one word-write per assembled instruction and holds the core in reset until the image loads cleanly.
- Sits beside the core at top level; its write port muxes into the instruction memory while hold_cpu is high.

Parameters:
- ADDR_W, 10, word-address width; capacity is 2^ADDR_W words.
- MAX_WORDS, 1024, largest accepted word count; must be <= 2^ADDR_W.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte accepted when in_valid && in_ready at a clk edge.
- we  out  1  instruction-memory write enable, one cycle per word.
- waddr  out  ADDR_W  word address of the write.
- wdata  out  32  instruction word.
- hold_cpu  out  1  keeps the core in reset; high from reset until DONE.
- busy  out  1  high in LEN_HI, LEN_LO, DATA and CSUM.
- done  out  1  level; high in DONE.
- err  out  1  level; high in ERROR.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, in_ready=0, we=0, waddr=0, wdata=0, hold_cpu=1, busy=0, done=0, err=0. All internal counters, checksum and byte buffers are cleared.
- States:
  - IDLE: start -> LEN_HI.
  - LEN_HI: accepted byte -> len[15:8]; go to LEN_LO.
  - LEN_LO: accepted byte -> len[7:0].
    - len==0 -> CSUM.
    - len>MAX_WORDS -> ERROR.
    - otherwise -> DATA.
  - DATA: bytes are packed MSB-first. Byte 0 -> [31:24], byte 3 -> [7:0].
    - After the 4th byte is accepted, the next cycle has we=1, wdata=word and waddr=word index. The index starts at 0 and increments after each write.
    - After the word numbered len-1 is accepted -> CSUM.
  - CSUM: accepted byte == XOR of all DATA bytes -> DONE; otherwise -> ERROR.
  - DONE: hold_cpu=0, done=1. start -> LEN_HI, which clears done and sets hold_cpu=1 on that same edge.
  - ERROR: hold_cpu=1, err=1. start -> LEN_HI, clearing err.
- in_ready = 1 exactly while busy. The input side never back-pressures within a load.
- The write cycle overlaps acceptance of the next byte. Consecutive words can therefore complete every 4 cycles, and we pulses are never adjacent.
- Checksum covers DATA bytes only, not the length bytes. A length of 0 requires checksum byte 0x00.
- Word index never wraps, because len<=MAX_WORDS is enforced before DATA.
- start while busy: ignored. start and in_valid in the same cycle as IDLE->LEN_HI: the byte is not accepted (in_ready is still 0 that cycle).
- in_valid gaps: the state holds, and the partial word and checksum are retained.
- Reset mid-load: the load is abandoned and the partial word discarded. Words already written stay in memory. hold_cpu returns to 1.
- we is registered and never asserted outside DATA or in the single cycle after the last DATA byte.

Decomposition:
- Shared package:
  - state encoding constants: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR, 3 bits.
  - IM_ADDR_W=10, which also sizes the core's im port.
- Sub-module: byte_packer. Shifts 4 accepted bytes into a 32-bit word, raises word_rdy for one cycle, and keeps the running XOR. The FSM stays in imem_loader.

Test Plan:
- Nominal load:
  - stimulus: start; bytes 00 02, 3C 01 00 05, 00 00 00 0C, checksum.
  - checksum = 3C^01^00^05^00^00^00^0C = 0x34.
  - required: we at waddr 0 with 0x3C010005, then waddr 1 with 0x0000000C; then done=1, hold_cpu=0, err=0.
- Bad checksum:
  - stimulus: same stream with checksum 0x35.
  - required: two writes occur, then err=1, hold_cpu=1, done=0.
- Length limit:
  - stimulus: length bytes 04 01 (1025).
  - required: ERROR right after LEN_LO; no we pulses; in_ready=0 afterwards.
- Zero length with valid gaps:
  - stimulus: length 00 00, checksum 00, with in_valid low for 3 cycles between bytes.
  - required: DONE; no we; state held during the gaps.
- Reset mid-load and restart:
  - stimulus: rst=0 for one cycle after 6 DATA bytes; then start and a new 1-word image.
  - required: all outputs at reset values; the new word written at waddr 0; done=1.
- Start handling:
  - stimulus: start pulse while busy; separately, start after ERROR.
  - required: the pulse while busy has no effect; start after ERROR reloads successfully and clears err.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: state encoding and
// the instruction-memory word-address width.
package imem_loader_pkg;

  localparam int IM_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    CSUM   = 3'd4,
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

  // States in which the loader is consuming the byte stream.
  function automatic logic is_busy(input state_t s);
    return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
interface imem_loader_if import imem_loader_pkg::*; #(
  parameter int ADDR_W = IM_ADDR_W
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [31:0]       wdata;

  modport master (output in_valid, in_data, input in_ready, we, waddr, wdata);
  modport slave  (input in_valid, in_data, output in_ready, we, waddr, wdata);
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles big-endian 32-bit words from accepted bytes, pulses word_rdy for one
// cycle per completed word and keeps the running XOR of every byte it accepts.
module imem_loader_byte_packer import imem_loader_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  din,
  output logic        word_rdy,
  output logic [31:0] word,
  output logic        last_byte,
  output logic [7:0]  csum
);

  logic [1:0]  lane_reg;
  logic [23:0] shift_reg;
  logic [31:0] word_reg;
  logic        rdy_reg;
  logic [7:0]  xor_reg;
  logic [31:0] packed_next;

  // Newest byte enters the low lane; older bytes move up toward [31:24].
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    if (gi == 0) begin : g_new
      assign packed_next[7:0] = din;
    end else begin : g_old
      assign packed_next[8*gi +: 8] = shift_reg[8*(gi-1) +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lane_reg  <= 2'd0;
      shift_reg <= 24'd0;
      word_reg  <= 32'd0;
      rdy_reg   <= 1'b0;
      xor_reg   <= 8'd0;
    end else if (clear) begin
      lane_reg  <= 2'd0;
      shift_reg <= 24'd0;
      rdy_reg   <= 1'b0;
      xor_reg   <= 8'd0;
    end else begin
      rdy_reg <= 1'b0;
      if (accept) begin
        lane_reg <= lane_reg + 2'd1;
        xor_reg  <= xor_reg ^ din;
        if (lane_reg == 2'd3) begin
          word_reg <= packed_next;
          rdy_reg  <= 1'b1;
        end else begin
          shift_reg <= packed_next[23:0];
        end
      end
    end
  end

  assign word_rdy  = rdy_reg;
  assign word      = word_reg;
  assign last_byte = (lane_reg == 2'd3);
  assign csum      = xor_reg;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: length header, big-endian words, XOR
// checksum; holds the core in reset until an image has loaded cleanly.
module imem_loader import imem_loader_pkg::*; #(
  parameter int ADDR_W    = IM_ADDR_W,
  parameter int MAX_WORDS = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.slave  bus,
  output logic          hold_cpu,
  output logic          busy,
  output logic          done,
  output logic          err
);

  state_t            state_reg, state_next;
  logic [15:0]       len_reg;
  logic [ADDR_W-1:0] waddr_reg;
  logic              in_ready_reg;
  logic              hold_reg, busy_reg, done_reg, err_reg;

  logic        accept, data_accept, start_ok, last_word;
  logic        pk_rdy, pk_last;
  logic [31:0] pk_word;
  logic [7:0]  pk_csum;
  logic [15:0] len_full;
  logic [16:0] widx_next;

  assign accept      = bus.in_valid && in_ready_reg;
  assign data_accept = accept && (state_reg == DATA);
  assign start_ok    = start && ((state_reg == IDLE) || (state_reg == DONE) || (state_reg == ERROR));
  assign len_full    = {len_reg[15:8], bus.in_data};
  // waddr_reg already points at the word being assembled when its last byte arrives.
  assign widx_next   = 17'(waddr_reg) + 17'd1;
  assign last_word   = (widx_next == {1'b0, len_reg});

  imem_loader_byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (start_ok),
    .accept    (data_accept),
    .din       (bus.in_data),
    .word_rdy  (pk_rdy),
    .word      (pk_word),
    .last_byte (pk_last),
    .csum      (pk_csum)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE, ERROR: if (start) state_next = LEN_HI;
      LEN_HI: if (accept) state_next = LEN_LO;
      LEN_LO:
        if (accept) begin
          if (len_full == 16'd0)               state_next = CSUM;
          else if (32'(len_full) > MAX_WORDS)  state_next = ERROR;
          else                                 state_next = DATA;
        end
      DATA: if (accept && pk_last && last_word) state_next = CSUM;
      CSUM: if (accept) state_next = (bus.in_data == pk_csum) ? DONE : ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      len_reg      <= 16'd0;
      waddr_reg    <= '0;
      in_ready_reg <= 1'b0;
      hold_reg     <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= is_busy(state_next);
      busy_reg     <= is_busy(state_next);
      done_reg     <= (state_next == DONE);
      err_reg      <= (state_next == ERROR);
      hold_reg     <= (state_next != DONE);
      if (accept && (state_reg == LEN_HI)) len_reg[15:8] <= bus.in_data;
      if (accept && (state_reg == LEN_LO)) len_reg[7:0]  <= bus.in_data;
      // The final word's write lands in CSUM; the index stops there so it never wraps.
      if (start_ok)                            waddr_reg <= '0;
      else if (pk_rdy && (state_reg == DATA))  waddr_reg <= waddr_reg + 1'b1;
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign bus.we       = pk_rdy;
  assign bus.waddr    = waddr_reg;
  assign bus.wdata    = pk_word;
  assign hold_cpu     = hold_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized image loads checked against a byte-level model of the
// boot protocol: expected writes, checksum and final status are derived from the image.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int MAXW = 1024;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic hold_cpu, busy, done, err;

  imem_loader_if #(.ADDR_W(IM_ADDR_W)) bus ();

  imem_loader #(.ADDR_W(IM_ADDR_W), .MAX_WORDS(MAXW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .hold_cpu (hold_cpu),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0]          img[$];
  logic [IM_ADDR_W-1:0] cap_addr[$];
  logic [31:0]          cap_data[$];
  logic                 prev_we = 1'b0;
  logic                 adjacent = 1'b0;

  // Write-port monitor: records every write and flags back-to-back we pulses.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      cap_addr.push_back(bus.waddr);
      cap_data.push_back(bus.wdata);
      if (prev_we) adjacent <= 1'b1;
    end
    prev_we <= bus.we;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] img_xor(input int n);
    logic [7:0] x = 8'd0;
    for (int w = 0; w < n; w++)
      for (int k = 0; k < 4; k++)
        x = x ^ 8'((img[w] >> (8 * k)) & 32'hFF);
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit r = 1'b0;
    bus.in_valid = 1'b0;
    repeat (gap) begin
      @(negedge clk);
      check("gap_busy", {63'd0, busy}, 64'd1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk); #1;
      if (r) break;
    end
    if (!r) check("accept_timeout", {63'd0, r}, 64'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_image(input int len_field, input logic [7:0] csum,
                           input int gmin, input int gmax, input bit busy_start);
    logic [15:0] lf;
    logic [31:0] wd;
    lf = 16'(len_field);
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(lf[15:8], $urandom_range(gmax, gmin));
    send_byte(lf[7:0], $urandom_range(gmax, gmin));
    if (len_field <= MAXW) begin
      for (int w = 0; w < len_field; w++) begin
        wd = img[w];
        for (int k = 0; k < 4; k++) begin
          send_byte(wd[31-8*k -: 8], $urandom_range(gmax, gmin));
          if (busy_start && w == 0 && k == 0) pulse_start();
        end
      end
      send_byte(csum, $urandom_range(gmax, gmin));
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic check_outcome(input string tag, input int len_field, input logic [7:0] csum);
    int nw;
    int nc;
    bit ok;
    nw = (len_field <= MAXW) ? len_field : 0;
    ok = (len_field <= MAXW) && (csum == img_xor(nw));
    @(negedge clk);
    check({tag, "_nwrites"}, 64'(cap_addr.size()), 64'(nw));
    nc = (cap_addr.size() < nw) ? cap_addr.size() : nw;
    for (int i = 0; i < nc; i++) begin
      check($sformatf("%s_waddr%0d", tag, i), 64'(cap_addr[i]), 64'(i));
      check($sformatf("%s_wdata%0d", tag, i), 64'(cap_data[i]), 64'(img[i]));
    end
    check({tag, "_done"},     {63'd0, done},         {63'd0, ok});
    check({tag, "_err"},      {63'd0, err},          {63'd0, !ok});
    check({tag, "_hold"},     {63'd0, hold_cpu},     {63'd0, !ok});
    check({tag, "_busy"},     {63'd0, busy},         64'd0);
    check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check({tag, "_we"},       {63'd0, bus.we},       64'd0);
    $display("load %s: len=%0d csum=%02h writes=%0d done=%0b err=%0b",
             tag, len_field, csum, cap_addr.size(), done, err);
  endtask

  task automatic check_reset(input string tag);
    @(negedge clk);
    check({tag, "_in_ready"}, {63'd0, bus.in_ready}, 64'd0);
    check({tag, "_we"},       {63'd0, bus.we},       64'd0);
    check({tag, "_waddr"},    64'(bus.waddr),        64'd0);
    check({tag, "_wdata"},    64'(bus.wdata),        64'd0);
    check({tag, "_hold"},     {63'd0, hold_cpu},     64'd1);
    check({tag, "_busy"},     {63'd0, busy},         64'd0);
    check({tag, "_done"},     {63'd0, done},         64'd0);
    check({tag, "_err"},      {63'd0, err},          64'd0);
    $display("reset %s: hold_cpu=%0b busy=%0b", tag, hold_cpu, busy);
  endtask

  initial begin
    logic [7:0] cs;
    logic [31:0] wd;
    int n;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    @(posedge clk); #1;
    rst = 1'b1;

    // Nominal two-word image.
    img = '{32'h3C010005, 32'h0000000C};
    run_image(2, 8'h34, 0, 0, 0);
    check_outcome("nominal", 2, 8'h34);

    // Same image, wrong checksum.
    run_image(2, 8'h35, 0, 0, 0);
    check_outcome("bad_csum", 2, 8'h35);

    // Restart from ERROR, with a start pulse landing mid-DATA.
    run_image(2, 8'h34, 0, 1, 1);
    check_outcome("restart_busy_start", 2, 8'h34);

    // Length just over the limit.
    img.delete();
    run_image(MAXW + 1, 8'h00, 0, 0, 0);
    check_outcome("len_limit", MAXW + 1, 8'h00);

    // Zero-length image with three idle cycles before each byte.
    run_image(0, 8'h00, 3, 3, 0);
    check_outcome("zero_len_gaps", 0, 8'h00);

    // Reset after six DATA bytes of a two-word image.
    img = '{$urandom, $urandom};
    cap_addr.delete();
    cap_data.delete();
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h02, 0);
    for (int i = 0; i < 6; i++) begin
      wd = img[i / 4];
      send_byte(wd[31-8*(i%4) -: 8], 0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check_reset("mid_load");
    check("mid_load_nwrites", 64'(cap_addr.size()), 64'd1);
    if (cap_data.size() > 0) check("mid_load_word0", 64'(cap_data[0]), 64'(img[0]));
    img = '{$urandom};
    run_image(1, img_xor(1), 0, 0, 0);
    check_outcome("after_reset", 1, img_xor(1));

    // Randomized images, some with corrupted checksums.
    for (int t = 0; t < 8; t++) begin
      n = $urandom_range(6, 1);
      img.delete();
      for (int w = 0; w < n; w++) img.push_back($urandom);
      cs = img_xor(n);
      if ($urandom_range(3, 0) == 0) cs = cs ^ 8'($urandom_range(255, 1));
      run_image(n, cs, 0, 2, 0);
      check_outcome($sformatf("rand%0d", t), n, cs);
    end

    // Largest accepted image fills the whole memory.
    img.delete();
    for (int w = 0; w < MAXW; w++) img.push_back($urandom);
    run_image(MAXW, img_xor(MAXW), 0, 0, 0);
    check_outcome("max_len", MAXW, img_xor(MAXW));

    check("we_adjacent", {63'd0, adjacent}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
